// File: rtl/sha3_pkg.sv
// Shared SHA3 constants and helpers.
// No logic state; byte_rev is a pure combinational helper.
// No handshake of its own.
package sha3_pkg;

    localparam int SHA3_CHUNK_W    = 200;
    localparam int SHA3_NCHUNK     = 8;
    localparam int SHA3_IX_W       = 3;
    localparam int SHA3_LANE_W     = 64;
    localparam int SHA3_MAX_DIGEST = 512;

    // Reverse the byte order of the low nbytes of d; bytes above nbytes are returned as 0.
    function automatic logic [SHA3_MAX_DIGEST-1:0] byte_rev(input logic [SHA3_MAX_DIGEST-1:0] d,
                                                           input int nbytes);
        logic [SHA3_MAX_DIGEST-1:0] r;
        r = '0;
        for (int i = 0; i < SHA3_MAX_DIGEST / 8; i++) begin
            if (i < nbytes) begin
                r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sha3_digest_bank.sv
// One reassembly bank: arrival mask, leading DBITS of the state, full flag.
// Latency: full sets on the edge that captures the 8th distinct chunk.
// No backpressure of its own; the caller only writes when the bank is free or being cleared.
module sha3_digest_bank
    import sha3_pkg::*;
#(
    parameter int DBITS = 256
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [SHA3_IX_W-1:0]    ix,
    input  logic [SHA3_CHUNK_W-1:0] data,
    input  logic                    clr,
    output logic [SHA3_NCHUNK-1:0]  mask,
    output logic                    full,
    output logic                    dup,
    output logic                    complete,
    output logic [DBITS-1:0]        state
);

    logic [SHA3_NCHUNK-1:0] mask_base;
    logic [SHA3_NCHUNK-1:0] mask_nxt;
    logic [DBITS-1:0]       wr_dat;
    logic [DBITS-1:0]       wr_msk;

    // A clear in the same cycle as a write means the write starts a fresh block.
    always_comb begin
        mask_base = clr ? '0 : mask;
        mask_nxt  = mask_base | (SHA3_NCHUNK'(1) << ix);
        dup       = we && mask_base[ix];
        complete  = we && (mask_base != '1) && (mask_nxt == '1);
    end

    // Chunks lying wholly above the digest shift out of range and only touch the mask.
    always_comb begin
        wr_dat = DBITS'(data) << (SHA3_CHUNK_W * int'(ix));
        wr_msk = DBITS'({SHA3_CHUNK_W{1'b1}}) << (SHA3_CHUNK_W * int'(ix));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask  <= '0;
            full  <= 1'b0;
            state <= '0;
        end else begin
            if (we) begin
                mask  <= mask_nxt;
                state <= (state & ~wr_msk) | wr_dat;
            end else if (clr) begin
                mask <= '0;
            end
            if (complete) begin
                full <= 1'b1;
            end else if (clr) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sha3_digest_collect.sv
// Reassembles 8 permutation chunks into a state and presents its leading DIGEST_BITS as a digest.
// Latency: digest_valid rises the cycle after the 8th chunk of a block is pushed.
// Input has no backpressure: two ping-pong banks; a push with no free bank is dropped (err_ovf).
module sha3_digest_collect
    import sha3_pkg::*;
#(
    parameter int DIGEST_BITS = 256,
    parameter int BYTE_SWAP   = 0
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SHA3_IX_W-1:0]    chunk_ix,
    input  logic [SHA3_CHUNK_W-1:0] chunk_data,
    input  logic                    chunk_push,
    output logic [DIGEST_BITS-1:0]  digest,
    output logic                    digest_valid,
    input  logic                    digest_ready,
    output logic                    busy,
    output logic                    err_dup,
    output logic                    err_ovf
);

    logic                   wr_bank;
    logic                   rd_bank;
    logic                   pop;
    logic                   accept;
    logic [1:0]             we;
    logic [1:0]             clr;
    logic [1:0]             full;
    logic [1:0]             dup;
    logic [1:0]             complete;
    logic [SHA3_NCHUNK-1:0] mask  [2];
    logic [DIGEST_BITS-1:0] state [2];
    logic [DIGEST_BITS-1:0] sel;

    assign pop    = full[rd_bank] && digest_ready;
    // A full write bank is still writable when it is the one being popped this cycle.
    assign accept = chunk_push && (!full[wr_bank] || (pop && (rd_bank == wr_bank)));

    for (genvar g = 0; g < 2; g++) begin : g_bank
        assign we[g]  = accept && (wr_bank == 1'(g));
        assign clr[g] = pop && (rd_bank == 1'(g));

        sha3_digest_bank #(
            .DBITS(DIGEST_BITS)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .we       (we[g]),
            .ix       (chunk_ix),
            .data     (chunk_data),
            .clr      (clr[g]),
            .mask     (mask[g]),
            .full     (full[g]),
            .dup      (dup[g]),
            .complete (complete[g]),
            .state    (state[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            err_dup <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (|complete) begin
                wr_bank <= ~wr_bank;
            end
            if (pop) begin
                rd_bank <= ~rd_bank;
            end
            if (|dup) begin
                err_dup <= 1'b1;
            end
            if (chunk_push && !accept) begin
                err_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        sel = state[rd_bank];
        if (BYTE_SWAP != 0) begin
            digest = DIGEST_BITS'(byte_rev(SHA3_MAX_DIGEST'(sel), DIGEST_BITS / 8));
        end else begin
            digest = sel;
        end
    end

    assign digest_valid = full[rd_bank];
    assign busy         = (|mask[0]) | (|mask[1]) | (|full);

endmodule
